// File: rtl/pipe_defs.sv
// Shared pipeline definitions: fetch FSM state encoding and the NOP bubble word.
package pipe_defs;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds inst, pc_to_id and inst_valid.
// bubble has priority over load; neither asserted means hold.
module if_id_reg
    import pipe_defs::*;
#(
    parameter logic [31:0] NOP_INST = NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] rdata,
    input  logic [31:0] pc_next,
    output logic [31:0] inst,
    output logic [31:0] pc_to_id,
    output logic        inst_valid
);

    // Register update: bubble clears the slot but keeps pc_to_id, load captures a fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst       <= NOP_INST;
            pc_to_id   <= '0;
            inst_valid <= 1'b0;
        end else if (bubble) begin
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
        end else if (load) begin
            inst       <= rdata;
            pc_to_id   <= pc_next;
            inst_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a wait-stated imem port and the IF/ID register.
// A redirect arriving while a fetch is outstanding is parked in redir_q (DISCARD) until
// that fetch completes; its data is then dropped.
// Optional macro PERF_CNT_EN adds perf_fetch / perf_flush / perf_stall counters.
module if_stage
    import pipe_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             IF_Flush,
    input  logic             PCSrc,
    input  logic             Jump,
    input  logic [31:0]      branch_add,
    input  logic [31:0]      jump_add,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      inst,
    output logic [31:0]      pc_to_id,
    output logic             inst_valid
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_fetch,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] tgt, pc_plus4;
    logic        ld, bub;

    // PCSrc only qualifies IF_Flush upstream; target choice depends on Jump alone.
    logic        unused_pcsrc;
    assign unused_pcsrc = PCSrc;

    assign tgt       = Jump ? jump_add : branch_add;
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;

    // State, PC and parked redirect target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
        end
    end

    // Next-state, PC selection, request and IF/ID control.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        redir_d  = redir_q;
        imem_req = 1'b0;
        ld       = 1'b0;
        bub      = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (IF_Flush) pc_d = tgt;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (IF_Flush) begin
                    bub = 1'b1;
                    if (imem_ready) begin
                        pc_d = tgt;
                    end else begin
                        redir_d = tgt;
                        state_d = DISCARD;
                    end
                end else if (imem_ready) begin
                    if (PCWrite && IF_ID_Write) begin
                        ld   = 1'b1;
                        pc_d = pc_plus4;
                    end
                end else if (IF_ID_Write) begin
                    bub = 1'b1;
                end
            end
            DISCARD: begin
                imem_req = 1'b1;
                if (IF_Flush) begin
                    bub     = 1'b1;
                    redir_d = tgt;
                end
                if (imem_ready) begin
                    pc_d    = IF_Flush ? tgt : redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (ld),
        .bubble     (bub),
        .rdata      (imem_rdata),
        .pc_next    (pc_plus4),
        .inst       (inst),
        .pc_to_id   (pc_to_id),
        .inst_valid (inst_valid)
    );

`ifdef PERF_CNT_EN
    // Event counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch <= '0;
            perf_flush <= '0;
            perf_stall <= '0;
        end else begin
            perf_fetch <= perf_fetch + CNT_W'(ld);
            perf_flush <= perf_flush + CNT_W'(IF_Flush);
            perf_stall <= perf_stall + CNT_W'(imem_req & ~imem_ready);
        end
    end
`endif

endmodule
